mem_cmd_gen: RTL and testbench

MEM_CMD_GEN -- requirements
Module: mem_cmd_gen

---
 rtl/mem_cmd_gen.sv | 184 ++++++++++++++++++
 tb/tb_mem_cmd_gen.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_cmd_gen.sv
// Purpose : single-request DDR4 command sequencer. Each accepted request becomes
//           PRE/ACT/RD/WR commands chosen from a per-bank open-row table and
//           spaced by the TRCD/TRP/TRAS/TCCD limits.
// Latency : first command 2 cycles after accept (miss: ACT; hit: RD/WR if TCCD allows),
//           ready again the cycle after the RD/WR is on the bus.
// Backpressure: req_ready is high only in IDLE; requests are never buffered and the
//           request inputs are ignored while a request is in flight.
// Ports   : clk/reset (sync, active-high); req_* request handshake and fields;
//           cs_n/act_n/A/bg/ba/cke registered DDR4 command bus; rsp_valid/rsp_write
//           pulse with the RD/WR; busy = FSM not idle.
module mem_cmd_gen #(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int TRCD      = 4,
    parameter int TRP       = 4,
    parameter int TRAS      = 10,
    parameter int TCCD      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0]  req_col,
    output logic                 cs_n,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic                 cke,
    output logic                 rsp_valid,
    output logic                 rsp_write,
    output logic                 busy
);
    localparam int BKW   = BGWIDTH + BAWIDTH;
    localparam int NBANK = 1 << BKW;
    // A16/A15/A14 double as RAS_n/CAS_n/WE_n when act_n is high
    localparam int A_RAS = 16;
    localparam int A_CAS = 15;
    localparam int A_WE  = 14;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DECODE   = 3'd1;
    localparam logic [2:0] ST_PRE      = 3'd2;
    localparam logic [2:0] ST_PRE_WAIT = 3'd3;
    localparam logic [2:0] ST_ACT      = 3'd4;
    localparam logic [2:0] ST_ACT_WAIT = 3'd5;
    localparam logic [2:0] ST_CAS      = 3'd6;

    logic [2:0]           state, state_nxt;
    logic                 lat_write;
    logic [BGWIDTH-1:0]   lat_bg;
    logic [BAWIDTH-1:0]   lat_ba;
    logic [ADDRWIDTH-1:0] lat_row;
    logic [COLWIDTH-1:0]  lat_col;
    logic [BKW-1:0]       bank_idx;

    logic [NBANK-1:0]     open_q;
    logic [ADDRWIDTH-1:0] open_row [NBANK];
    logic [5:0]           tras_cnt [NBANK];
    logic [5:0]           tccd_cnt;
    logic [5:0]           wait_cnt;   // TRP after PRE, TRCD after ACT

    logic                 accept, cmd_on;
    logic                 issue_pre, issue_act, issue_cas;
    logic [ADDRWIDTH-1:0] pre_a, cas_a;

    assign bank_idx = {lat_bg, lat_ba};
    assign accept   = req_valid && req_ready;
    assign cmd_on   = ~cs_n;            // the current state's command is on the bus now
    assign busy     = (state != ST_IDLE);

    // The command-holding states (PRE, ACT, CAS) put their command on the bus in
    // their final cycle. The decision is made one cycle early so that the command
    // registers load in step with the state register.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (accept) state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (!open_q[bank_idx])                     state_nxt = ST_ACT;
                else if (open_row[bank_idx] == lat_row)    state_nxt = ST_CAS;
                else                                       state_nxt = ST_PRE;
            end
            ST_PRE:      if (cmd_on) state_nxt = (wait_cnt <= 6'd1) ? ST_ACT : ST_PRE_WAIT;
            ST_PRE_WAIT: if (wait_cnt <= 6'd1) state_nxt = ST_ACT;
            ST_ACT:      state_nxt = (wait_cnt <= 6'd1) ? ST_CAS : ST_ACT_WAIT;
            ST_ACT_WAIT: if (wait_cnt <= 6'd1) state_nxt = ST_CAS;
            ST_CAS:      if (cmd_on) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // ACT is only ever entered once its TRP slot has arrived (or the bank is closed),
    // so it always issues on entry. PRE and CAS wait on their down-counters, which
    // read <=1 in the cycle before the command becomes legal.
    always_comb begin
        issue_pre = (state_nxt == ST_PRE) && !(state == ST_PRE && cmd_on)
                    && (tras_cnt[bank_idx] <= 6'd1);
        issue_act = (state_nxt == ST_ACT) && (state != ST_ACT);
        issue_cas = (state_nxt == ST_CAS) && !(state == ST_CAS && cmd_on)
                    && (tccd_cnt <= 6'd1);
    end

    always_comb begin
        pre_a        = '0;
        pre_a[A_CAS] = 1'b1;
        cas_a                 = '0;
        cas_a[COLWIDTH-1:0]   = lat_col;
        cas_a[A_RAS]          = 1'b1;
        cas_a[A_WE]           = ~lat_write;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            req_ready <= 1'b0;
            cke       <= 1'b0;
            cs_n      <= 1'b1;
            act_n     <= 1'b1;
            A         <= '0;
            bg        <= '0;
            ba        <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            open_q    <= '0;
            tccd_cnt  <= '0;
            wait_cnt  <= '0;
            for (int i = 0; i < NBANK; i++) begin
                tras_cnt[i] <= '0;
                open_row[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            req_ready <= (state_nxt == ST_IDLE);
            cke       <= 1'b1;

            if (accept) begin
                lat_write <= req_write;
                lat_bg    <= req_bg;
                lat_ba    <= req_ba;
                lat_row   <= req_row;
                lat_col   <= req_col;
            end

            // command bus: deselect unless a command is issued this edge
            cs_n  <= ~(issue_pre | issue_act | issue_cas);
            act_n <= ~issue_act;
            bg    <= (issue_pre | issue_act | issue_cas) ? lat_bg : '0;
            ba    <= (issue_pre | issue_act | issue_cas) ? lat_ba : '0;
            if (issue_act)      A <= lat_row;
            else if (issue_pre) A <= pre_a;
            else if (issue_cas) A <= cas_a;
            else                A <= '0;

            rsp_valid <= issue_cas;
            rsp_write <= issue_cas & lat_write;

            if (issue_act) begin
                open_q[bank_idx]   <= 1'b1;
                open_row[bank_idx] <= lat_row;
            end else if (issue_pre) begin
                open_q[bank_idx]   <= 1'b0;
            end

            for (int i = 0; i < NBANK; i++) begin
                if (issue_act && bank_idx == BKW'(i)) tras_cnt[i] <= 6'(TRAS);
                else if (tras_cnt[i] != 6'd0)         tras_cnt[i] <= tras_cnt[i] - 6'd1;
            end

            if (issue_cas)              tccd_cnt <= 6'(TCCD);
            else if (tccd_cnt != 6'd0)  tccd_cnt <= tccd_cnt - 6'd1;

            if (issue_pre)              wait_cnt <= 6'(TRP);
            else if (issue_act)         wait_cnt <= 6'(TRCD);
            else if (wait_cnt != 6'd0)  wait_cnt <= wait_cnt - 6'd1;
        end
    end
endmodule

// File: tb/tb_mem_cmd_gen.sv
module tb_mem_cmd_gen;
    localparam int AW = 17, CW = 10, BGW = 2, BAW = 2;

    typedef struct {
        int               cyc;
        logic             act_n;
        logic [AW-1:0]    a;
        logic [BGW-1:0]   bg;
        logic [BAW-1:0]   ba;
        logic             rsp;
        logic             rspw;
    } cmd_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_smp = 1'b1;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_smp <= reset;
    end

    logic            req_valid = 1'b0, req_write = 1'b0;
    logic [BGW-1:0]  req_bg = '0;
    logic [BAW-1:0]  req_ba = '0;
    logic [AW-1:0]   req_row = '0;
    logic [CW-1:0]   req_col = '0;
    int              sel = 0;

    logic [1:0]      vld;
    logic            rdy_o [2], cs_n_o [2], act_n_o [2], cke_o [2], rsp_o [2], rspw_o [2], busy_o [2];
    logic [AW-1:0]   a_o [2];
    logic [BGW-1:0]  bg_o [2];
    logic [BAW-1:0]  ba_o [2];

    assign vld[0] = req_valid && (sel == 0);
    assign vld[1] = req_valid && (sel == 1);

    mem_cmd_gen dut0 (
        .clk(clk), .reset(reset), .req_valid(vld[0]), .req_ready(rdy_o[0]),
        .req_write(req_write), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .cs_n(cs_n_o[0]), .act_n(act_n_o[0]), .A(a_o[0]), .bg(bg_o[0]), .ba(ba_o[0]), .cke(cke_o[0]),
        .rsp_valid(rsp_o[0]), .rsp_write(rspw_o[0]), .busy(busy_o[0]));

    mem_cmd_gen #(.TRCD(1), .TRP(1), .TRAS(6), .TCCD(4)) dut1 (
        .clk(clk), .reset(reset), .req_valid(vld[1]), .req_ready(rdy_o[1]),
        .req_write(req_write), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .cs_n(cs_n_o[1]), .act_n(act_n_o[1]), .A(a_o[1]), .bg(bg_o[1]), .ba(ba_o[1]), .cke(cke_o[1]),
        .rsp_valid(rsp_o[1]), .rsp_write(rspw_o[1]), .busy(busy_o[1]));

    logic m_rdy, m_cs_n, m_act_n, m_cke, m_rsp, m_rspw, m_busy;
    logic [AW-1:0]  m_a;
    logic [BGW-1:0] m_bg;
    logic [BAW-1:0] m_ba;
    assign m_rdy = rdy_o[sel];   assign m_cs_n = cs_n_o[sel]; assign m_act_n = act_n_o[sel];
    assign m_cke = cke_o[sel];   assign m_rsp  = rsp_o[sel];  assign m_rspw  = rspw_o[sel];
    assign m_busy = busy_o[sel]; assign m_a    = a_o[sel];    assign m_bg    = bg_o[sel];
    assign m_ba  = ba_o[sel];

    int checks = 0;
    int errors = 0;

    // bus monitor: every command cycle is logged, every other cycle must be deselect
    cmd_t obs_q [$];
    cmd_t mon;
    always @(negedge clk) begin
        if (cyc >= 1) begin
            checks++;
            assert (m_cke === ~rst_smp) else begin
                errors++; $error("FAIL cke cyc=%0d observed %b required %b", cyc, m_cke, ~rst_smp);
            end
            if (m_cs_n === 1'b0) begin
                mon.cyc = cyc; mon.act_n = m_act_n; mon.a = m_a; mon.bg = m_bg; mon.ba = m_ba;
                mon.rsp = m_rsp; mon.rspw = m_rspw;
                obs_q.push_back(mon);
            end else begin
                checks++;
                assert ({m_cs_n, m_act_n, m_a, m_bg, m_ba, m_rsp} === {2'b11, (AW+BGW+BAW+1)'(0)}) else begin
                    errors++;
                    $error("FAIL deselect cyc=%0d observed cs_n=%b act_n=%b A=%h bg=%h ba=%h rsp=%b required 1/1/0/0/0/0",
                           cyc, m_cs_n, m_act_n, m_a, m_bg, m_ba, m_rsp);
                end
            end
        end
    end

    // reference model: command times derived directly from the timing rules
    bit            m_open [2][16];
    logic [AW-1:0] m_row  [2][16];
    int            m_lact [2][16];
    int            m_lcas [2];

    function automatic int p_trcd(int s); return (s == 0) ? 4 : 1; endfunction
    function automatic int p_trp(int s);  return (s == 0) ? 4 : 1; endfunction
    function automatic int p_tras(int s); return (s == 0) ? 10 : 6; endfunction
    function automatic int p_tccd(int s); return 4; endfunction
    function automatic int imax(int x, int y); return (x > y) ? x : y; endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_lcas[s] = -1000;
            for (int b = 0; b < 16; b++) begin
                m_open[s][b] = 0; m_row[s][b] = '0; m_lact[s][b] = -1000;
            end
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (m_rdy !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        checks++;
        assert (m_rdy === 1'b1) else begin
            errors++; $error("FAIL ready_timeout observed %b required 1", m_rdy);
        end
    endtask

    task automatic do_req(input logic w, input logic [BGW-1:0] g, input logic [BAW-1:0] ba_i,
                          input logic [AW-1:0] row, input logic [CW-1:0] col, input int gap,
                          output int t0, output int tfirst, output int tcas, output int trdy);
        cmd_t e [$];
        cmd_t c;
        int b, tp, ta, tc, n;
        repeat (gap) @(negedge clk);
        wait_ready();
        t0 = cyc;
        req_valid = 1'b1; req_write = w; req_bg = g; req_ba = ba_i; req_row = row; req_col = col;
        @(posedge clk); #1;
        // junk on the request port while busy must be ignored
        req_write = 1'($urandom); req_bg = BGW'($urandom); req_ba = BAW'($urandom);
        req_row = AW'($urandom); req_col = CW'($urandom);

        b = int'({g, ba_i});
        c.bg = g; c.ba = ba_i; c.rsp = 1'b0; c.rspw = 1'b0;
        if (m_open[sel][b] && m_row[sel][b] == row) begin
            tc = imax(t0 + 2, m_lcas[sel] + p_tccd(sel));
        end else begin
            if (m_open[sel][b]) begin
                tp = imax(t0 + 2, m_lact[sel][b] + p_tras(sel));
                c.cyc = tp; c.act_n = 1'b1; c.a = AW'(17'h08000); e.push_back(c);
                ta = tp + p_trp(sel);
            end else begin
                ta = t0 + 2;
            end
            c.cyc = ta; c.act_n = 1'b0; c.a = row; e.push_back(c);
            tc = imax(ta + p_trcd(sel), m_lcas[sel] + p_tccd(sel));
            m_open[sel][b] = 1; m_row[sel][b] = row; m_lact[sel][b] = ta;
        end
        c.cyc = tc; c.act_n = 1'b1; c.a = (w ? AW'(17'h10000) : AW'(17'h14000)) | AW'(col);
        c.rsp = 1'b1; c.rspw = w; e.push_back(c);
        m_lcas[sel] = tc;

        @(negedge clk);
        checks++;
        assert ({m_busy, m_rdy} === 2'b10) else begin
            errors++; $error("FAIL busy_after_accept observed busy=%b ready=%b required 1/0", m_busy, m_rdy);
        end
        n = 0;
        while (m_rdy !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        trdy = cyc;
        req_valid = 1'b0;
        checks++;
        assert (trdy === tc + 1 && m_busy === 1'b0) else begin
            errors++; $error("FAIL ready_return observed cyc=%0d busy=%b required cyc=%0d busy=0", trdy, m_busy, tc + 1);
        end
        checks++;
        assert (obs_q.size() === e.size()) else begin
            errors++; $error("FAIL cmd_count observed %0d required %0d", obs_q.size(), e.size());
        end
        for (int i = 0; i < e.size() && i < obs_q.size(); i++) begin
            checks++;
            assert (obs_q[i].cyc === e[i].cyc &&
                    {obs_q[i].act_n, obs_q[i].a, obs_q[i].bg, obs_q[i].ba, obs_q[i].rsp, obs_q[i].rspw} ===
                    {e[i].act_n, e[i].a, e[i].bg, e[i].ba, e[i].rsp, e[i].rspw}) else begin
                errors++;
                $error("FAIL cmd[%0d] observed cyc=%0d act_n=%b A=%h bg=%h ba=%h rsp=%b/%b required cyc=%0d act_n=%b A=%h bg=%h ba=%h rsp=%b/%b",
                       i, obs_q[i].cyc, obs_q[i].act_n, obs_q[i].a, obs_q[i].bg, obs_q[i].ba, obs_q[i].rsp, obs_q[i].rspw,
                       e[i].cyc, e[i].act_n, e[i].a, e[i].bg, e[i].ba, e[i].rsp, e[i].rspw);
            end
        end
        tfirst = (obs_q.size() > 0) ? obs_q[0].cyc : -1;
        tcas   = (obs_q.size() > 0) ? obs_q[obs_q.size()-1].cyc : -1;
        obs_q.delete();
    endtask

    initial begin
        int t0, tf, tc, tr, base, prev_cas;
        model_reset();

        // reset state
        @(negedge clk); @(negedge clk);
        checks++;
        assert ({m_rdy, m_cke, m_busy, m_rsp, m_rspw, m_cs_n} === 6'b000001) else begin
            errors++; $error("FAIL reset_outputs observed rdy/cke/busy/rsp/rspw/cs_n=%b%b%b%b%b%b required 000001",
                             m_rdy, m_cke, m_busy, m_rsp, m_rspw, m_cs_n);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        assert ({m_rdy, m_cke} === 2'b11) else begin
            errors++; $error("FAIL post_reset observed rdy=%b cke=%b required 1/1", m_rdy, m_cke);
        end

        // closed-bank read, then conflict write on the same bank, then a row hit
        do_req(1'b0, 2'd1, 2'd2, 17'h01ABC, 10'h005, 0, t0, tf, tc, tr);
        base = t0;
        checks++;
        assert (tf - base === 2 && tc - base === 6 && tr - base === 7) else begin
            errors++; $error("FAIL closed_read observed act=%0d rd=%0d rdy=%0d required 2/6/7", tf - base, tc - base, tr - base);
        end
        do_req(1'b1, 2'd1, 2'd2, 17'h00001, 10'h010, 0, t0, tf, tc, tr);
        checks++;
        assert (t0 - base === 7 && tf - base === 12 && tc - base === 20) else begin
            errors++; $error("FAIL conflict_write observed acc=%0d pre=%0d wr=%0d required 7/12/20", t0 - base, tf - base, tc - base);
        end
        prev_cas = tc;
        do_req(1'b0, 2'd1, 2'd2, 17'h00001, 10'h3FF, 0, t0, tf, tc, tr);
        checks++;
        assert (t0 === prev_cas + 1 && tc - prev_cas === 4 && tf === tc) else begin
            errors++; $error("FAIL row_hit_tccd observed rd-prev=%0d first=%0d required 4 and first==rd", tc - prev_cas, tf);
        end

        // reset during ACT_WAIT abandons the request; bank then reads as closed
        wait_ready();
        t0 = cyc;
        req_valid = 1'b1; req_write = 1'b0; req_bg = 2'd3; req_ba = 2'd3; req_row = 17'h00777; req_col = 10'h001;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            assert ({m_rdy, m_cke, m_busy, m_rsp, m_rspw} === 5'b00000) else begin
                errors++; $error("FAIL reset_in_act_wait observed rdy/cke/busy/rsp/rspw=%b%b%b%b%b required 00000",
                                 m_rdy, m_cke, m_busy, m_rsp, m_rspw);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        assert ({m_rdy, m_cke, m_busy} === 3'b110) else begin
            errors++; $error("FAIL reset_release observed rdy=%b cke=%b busy=%b required 1/1/0", m_rdy, m_cke, m_busy);
        end
        checks++;
        assert (obs_q.size() === 1 && obs_q[0].cyc === t0 + 2 && obs_q[0].act_n === 1'b0) else begin
            errors++; $error("FAIL reset_abandon observed %0d cmds required only the ACT at %0d", obs_q.size(), t0 + 2);
        end
        obs_q.delete();
        model_reset();
        do_req(1'b0, 2'd3, 2'd3, 17'h00777, 10'h001, 0, t0, tf, tc, tr);
        checks++;
        assert (tf === t0 + 2) else begin
            errors++; $error("FAIL post_reset_miss observed first=%0d required %0d", tf, t0 + 2);
        end

        // randomized traffic on a few banks/rows so hits, misses and conflicts all occur
        for (int i = 0; i < 40; i++) begin
            do_req(1'($urandom), BGW'($urandom_range(0, 1)), BAW'($urandom_range(0, 3)),
                   AW'($urandom_range(0, 2)), CW'($urandom), $urandom_range(0, 3), t0, tf, tc, tr);
        end

        // TRCD=1 / TRP=1 instance
        sel = 1;
        do_req(1'b0, 2'd0, 2'd0, 17'h00005, 10'h002, 0, t0, tf, tc, tr);
        checks++;
        assert (tc - tf === 1) else begin
            errors++; $error("FAIL fast_miss observed rd-act=%0d required 1", tc - tf);
        end
        do_req(1'b1, 2'd0, 2'd0, 17'h00006, 10'h004, 0, t0, tf, tc, tr);
        checks++;
        assert (tc - tf === 2) else begin
            errors++; $error("FAIL fast_conflict observed wr-pre=%0d required 2", tc - tf);
        end
        for (int i = 0; i < 15; i++) begin
            do_req(1'($urandom), BGW'($urandom_range(0, 1)), BAW'($urandom_range(0, 1)),
                   AW'($urandom_range(0, 2)), CW'($urandom), $urandom_range(0, 2), t0, tf, tc, tr);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
